seq_shift_unit: RTL and testbench



---
 rtl/seq_shift_pkg.sv | 17 +
 rtl/seq_shift_step.sv | 44 ++++
 rtl/seq_shift_unit.sv | 142 ++++++++++++++
 tb/tb_seq_shift_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_pkg.sv
// Shared definitions for the sequential shift/rotate unit: mode codes,
// FSM state encoding and default datapath sizes.
package seq_shift_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  localparam logic [1:0] MODE_SRL  = 2'b00;
  localparam logic [1:0] MODE_ROL  = 2'b01;
  localparam logic [1:0] MODE_ASL  = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

endpackage

// File: rtl/seq_shift_step.sv
// One-bit shift step: given the working value and the mode, produce the
// value after a single step, the bit that leaves it and the ASL sign-change bit.
module seq_shift_step
  import seq_shift_pkg::*;
#(
  parameter int W = WIDTH_DEF
) (
  input  logic [W-1:0] d,
  input  logic [1:0]   mode,
  output logic [W-1:0] d_next,
  output logic         carry_bit,
  output logic         ovf_bit
);

  // Select the single-bit transformation for the active mode
  always_comb begin
    d_next    = d;
    carry_bit = 1'b0;
    ovf_bit   = 1'b0;
    case (mode)
      MODE_SRL: begin
        d_next    = {1'b0, d[W-1:1]};
        carry_bit = d[0];
      end
      MODE_ROL: begin
        d_next    = {d[W-2:0], d[W-1]};
        carry_bit = d[W-1];
      end
      MODE_ASL: begin
        d_next    = {d[W-2:0], 1'b0};
        carry_bit = d[W-1];
        // sign changes on this step when the two top bits disagree
        ovf_bit   = d[W-1] ^ d[W-2];
      end
      default: begin
        // PASS leaves the value untouched and shifts nothing out
        d_next    = d;
        carry_bit = 1'b0;
        ovf_bit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle handshaked shift/rotate unit. Accepts an operand in IDLE,
// performs one bit step per clock in SHIFT, and presents the result in DONE
// until the consumer takes it. flush aborts any operation back to IDLE.
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Shift_in,
  input  logic [CNT_W-1:0] Shift_val,
  input  logic [1:0]       Mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Shift_out,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] data_r;
  logic [1:0]       mode_r;
  logic             carry_r;
  logic             ovf_r;
  logic [WIDTH-1:0] result_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic             accept_s;
  logic             step_s;
  logic             finish_s;
  logic [WIDTH-1:0] step_d_s;
  logic             step_carry_s;
  logic             step_ovf_s;

  seq_shift_step #(
    .W (WIDTH)
  ) u_step (
    .d         (data_r),
    .mode      (mode_r),
    .d_next    (step_d_s),
    .carry_bit (step_carry_s),
    .ovf_bit   (step_ovf_s)
  );

  // Decode the per-cycle events; flush suppresses all of them
  always_comb begin
    accept_s = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    if (flush) begin
      accept_s = 1'b0;
      step_s   = 1'b0;
      finish_s = 1'b0;
    end else begin
      accept_s = (state_r == IDLE) && in_valid;
      step_s   = (state_r == SHIFT) && (count_r != {CNT_W{1'b0}});
      finish_s = (state_r == SHIFT) && (count_r == {CNT_W{1'b0}});
    end
  end

  // Next-state logic; flush forces IDLE from any state
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) state_nxt_s = SHIFT;
          else          state_nxt_s = IDLE;
        end
        SHIFT: begin
          if (count_r == {CNT_W{1'b0}}) state_nxt_s = DONE;
          else                          state_nxt_s = SHIFT;
        end
        DONE: begin
          if (out_ready) state_nxt_s = IDLE;
          else           state_nxt_s = DONE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State, handshake flags, working value, count and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      count_r     <= {CNT_W{1'b0}};
      data_r      <= {WIDTH{1'b0}};
      mode_r      <= MODE_SRL;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      if (accept_s) begin
        data_r  <= Shift_in;
        mode_r  <= Mode;
        count_r <= Shift_val;
        carry_r <= 1'b0;
        ovf_r   <= 1'b0;
      end else if (step_s) begin
        data_r  <= step_d_s;
        count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        carry_r <= step_carry_s;
        ovf_r   <= ovf_r | step_ovf_s;
      end else begin
        data_r  <= data_r;
        count_r <= count_r;
        carry_r <= carry_r;
        ovf_r   <= ovf_r;
      end
      // the presented result only changes when an operation completes,
      // so an aborted operation leaves the previous result visible
      if (finish_s) result_r <= data_r;
      else          result_r <= result_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign Shift_out = result_r;
  assign carry     = carry_r;
  assign ovf       = ovf_r;
  // zero only carries meaning alongside a valid result
  assign zero      = out_valid_r & (result_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: directed cases from the block's intended use,
// backpressure / flush / async reset scenarios, then randomized traffic.
// A single monitor process compares the DUT against a behavioural model.
module tb_seq_shift_unit;
  import seq_shift_pkg::*;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] Shift_in  = 16'h0000;
  logic [3:0]  Shift_val = 4'd0;
  logic [1:0]  Mode      = 2'b00;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] Shift_out;
  logic        carry;
  logic        zero;
  logic        ovf;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int to_cnt      = 0;
  int to_seen     = 0;

  seq_shift_unit #(.WIDTH(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Shift_in  (Shift_in),
    .Shift_val (Shift_val),
    .Mode      (Mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Shift_out (Shift_out),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Whole-operation reference: result of n single-bit steps in closed form
  function automatic void model(input logic [1:0] m, input logic [15:0] d,
                                input logic [3:0] n, output logic [15:0] r,
                                output logic c, output logic v);
    logic [31:0] t;
    logic [31:0] s;
    logic [31:0] mask;
    int k;
    k = int'(n);
    r = d; c = 1'b0; v = 1'b0;
    case (m)
      MODE_SRL: begin
        t = {d, 16'h0000} >> k;
        r = t[31:16];
        c = (k == 0) ? 1'b0 : t[15];
      end
      MODE_ROL: begin
        t = {d, d} << k;
        r = t[31:16];
        c = (k == 0) ? 1'b0 : r[0];
      end
      MODE_ASL: begin
        t = {16'h0000, d} << k;
        r = t[15:0];
        c = (k == 0) ? 1'b0 : t[16];
        // sign changes somewhere iff the top k+1 original bits are not all equal
        s = {16'h0000, d} >> (15 - k);
        mask = (32'd1 << (k + 1)) - 32'd1;
        v = (s != 32'd0) && (s != mask);
      end
      default: begin
        r = d; c = 1'b0; v = 1'b0;
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pins the model, then checks every sample point against it
  initial begin : monitor
    logic        busy;
    logic        exp_v;
    logic [15:0] er;
    logic        ec;
    logic        ev;
    logic [15:0] r;
    logic        c;
    logic        v;
    int          ready_cyc;
    busy = 1'b0; er = 16'h0000; ec = 1'b0; ev = 1'b0; ready_cyc = 0;

    model(MODE_SRL, 16'h8001, 4'd4, r, c, v);
    chk("pin_srl4_r", 32'(r), 32'h0800); chk("pin_srl4_c", 32'(c), 32'd0);
    model(MODE_ROL, 16'h8001, 4'd1, r, c, v);
    chk("pin_rol1_r", 32'(r), 32'h0003); chk("pin_rol1_c", 32'(c), 32'd1);
    model(MODE_SRL, 16'h0001, 4'd1, r, c, v);
    chk("pin_srl1_r", 32'(r), 32'h0000); chk("pin_srl1_c", 32'(c), 32'd1);
    model(MODE_ASL, 16'h4000, 4'd1, r, c, v);
    chk("pin_asl1_r", 32'(r), 32'h8000); chk("pin_asl1_v", 32'(v), 32'd1);
    model(MODE_ASL, 16'h0003, 4'd2, r, c, v);
    chk("pin_asl2_r", 32'(r), 32'h000C); chk("pin_asl2_v", 32'(v), 32'd0);
    model(MODE_PASS, 16'hBEEF, 4'd15, r, c, v);
    chk("pin_pass_r", 32'(r), 32'hBEEF); chk("pin_pass_c", 32'(c), 32'd0);

    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (to_cnt != to_seen) begin
        vectors++;
        miscompares++;
        $display("FAIL handshake_timeout: got %0d expirations, expected 0", to_cnt - to_seen);
        to_seen = to_cnt;
      end
      if (rst) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_shift_out", 32'(Shift_out), 32'd0);
        chk("rst_carry",     32'(carry),     32'd0);
        chk("rst_zero",      32'(zero),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        busy = 1'b0;
      end else if (!clk) begin
        exp_v = busy && (cyc >= ready_cyc);
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        chk("in_ready",  32'(in_ready),  32'(!busy));
        if (exp_v && out_valid) begin
          chk("shift_out", 32'(Shift_out), 32'(er));
          chk("carry",     32'(carry),     32'(ec));
          chk("zero",      32'(zero),      32'(er == 16'h0000));
          chk("ovf",       32'(ovf),       32'(ev));
        end
        // advance the model by what the next rising edge will do
        if (flush) begin
          busy = 1'b0;
        end else if (!busy) begin
          if (in_valid) begin
            busy = 1'b1;
            model(Mode, Shift_in, Shift_val, er, ec, ev);
            ready_cyc = cyc + 2 + int'(Shift_val);
          end
        end else if (exp_v && out_ready) begin
          busy = 1'b0;
        end
      end
    end
  end

  // Present a request and hold it until the accept edge has passed
  task automatic send(input logic [1:0] m, input logic [15:0] d, input logic [3:0] n);
    int g;
    g = 0;
    in_valid = 1'b1; Mode = m; Shift_in = d; Shift_val = n;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 50) to_cnt++;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    Shift_in  = 16'($urandom);
    Shift_val = 4'($urandom);
    Mode      = 2'($urandom);
  endtask

  // Take the result as soon as it appears
  task automatic drain();
    int g;
    g = 0;
    out_ready = 1'b1;
    while (!out_valid && g < 40) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 40) to_cnt++;
    @(posedge clk); #1;
  endtask

  // Stimulus
  initial begin : driver
    int g;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    send(MODE_SRL,  16'h8001, 4'd4);  drain();
    send(MODE_ROL,  16'h8001, 4'd1);  drain();
    send(MODE_SRL,  16'h0001, 4'd1);  drain();
    send(MODE_ASL,  16'h4000, 4'd1);  drain();
    send(MODE_ASL,  16'h0003, 4'd2);  drain();
    send(MODE_SRL,  16'h1234, 4'd0);  drain();
    send(MODE_PASS, 16'hBEEF, 4'd15); drain();

    // backpressure with a competing request waiting
    out_ready = 1'b0;
    send(MODE_ASL, 16'h4000, 4'd1);
    g = 0;
    while (!out_valid && g < 40) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 40) to_cnt++;
    in_valid = 1'b1; Mode = MODE_SRL; Shift_in = 16'h00F0; Shift_val = 4'd2;
    repeat (3) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // flush mid-operation
    send(MODE_SRL, 16'hFFFF, 4'd10);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end

    // flush colliding with an accept
    in_valid = 1'b1; flush = 1'b1; Mode = MODE_ROL; Shift_in = 16'h1111; Shift_val = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end

    // asynchronous reset between edges mid-operation
    send(MODE_ROL, 16'hA5A5, 4'd12);
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom);
      Shift_in  = 16'($urandom);
      Shift_val = 4'($urandom);
      Mode      = 2'($urandom);
      out_ready = ($urandom_range(3, 0) != 0);
      flush     = ($urandom_range(49, 0) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard bound on total run time
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
